// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver: shared glyph decoder, dead-time, leading-zero blanking.
// Outputs registered (1 cycle after scan state); loads double-buffered and applied at digit-slot boundaries.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_in_i,
  input  logic                    mode_i,
  input  logic                    blank_lz_i,
  input  logic                    load_i,
  output logic [6:0]              leds_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o
);

  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] S_DEAD = SW'(DEAD_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    mode;
    logic                    blank_lz;
  } frame_t;

  frame_t                pend_q, pend_d;
  frame_t                act_q, act_d;
  logic [SW-1:0]         s_q, s_d;
  logic [DW-1:0]         d_q, d_d;
  logic [6:0]            leds_q, leds_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  wrap;
  logic                  in_dead;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] supp;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_supp;
  logic [0:6]            glyph_bits;

  // Bit strings are written a..g left to right, i.e. index 0 is segment a.
  function automatic logic [0:6] glyph(input logic [3:0] nib, input logic text);
    logic [0:6] g;
    case (nib)
      4'h0:    g = 7'b000_0001;
      4'h1:    g = 7'b100_1111;
      4'h2:    g = 7'b001_0010;
      4'h3:    g = 7'b000_0110;
      4'h4:    g = 7'b100_1100;
      4'h5:    g = 7'b010_0100;
      4'h6:    g = 7'b010_0000;
      4'h7:    g = 7'b000_1111;
      4'h8:    g = 7'b000_0000;
      4'h9:    g = 7'b000_0100;
      4'hA:    g = text ? 7'b111_0001 : 7'b000_1000;
      4'hB:    g = text ? 7'b000_0001 : 7'b110_0000;
      4'hC:    g = text ? 7'b010_0100 : 7'b011_0001;
      4'hD:    g = text ? 7'b011_0000 : 7'b100_0010;
      4'hE:    g = text ? 7'b111_1111 : 7'b011_0000;
      default: g = text ? 7'b111_1111 : 7'b011_1000;
    endcase
    return g;
  endfunction

  // Scanner and double buffer: active only changes on the slot wrap edge.
  always_comb begin
    wrap   = (s_q == S_LAST);
    s_d    = wrap ? '0 : s_q + SW'(1);
    d_d    = d_q;
    if (wrap) begin
      d_d = (d_q == D_LAST) ? '0 : d_q + DW'(1);
    end
    pend_d = pend_q;
    if (load_i) begin
      pend_d.value    = value_i;
      pend_d.dp       = dp_in_i;
      pend_d.mode     = mode_i;
      pend_d.blank_lz = blank_lz_i;
    end
    act_d = wrap ? pend_q : act_q;
  end

  // A digit is a leading zero if it and every more-significant nibble are zero.
  always_comb begin
    zero_run = 1'b1;
    supp     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (act_q.value[4*i +: 4] == 4'h0);
      supp[i]  = act_q.blank_lz & zero_run & (i != 0);
    end
  end

  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_supp = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (d_q == DW'(i)) begin
        cur_nib  = act_q.value[4*i +: 4];
        cur_dp   = act_q.dp[i];
        cur_supp = supp[i];
      end
    end
  end

  always_comb begin
    in_dead    = (s_q < S_DEAD);
    glyph_bits = glyph(cur_nib, act_q.mode);
    an_d       = '1;
    leds_d     = '1;
    dp_d       = 1'b1;
    if (!in_dead && !cur_supp) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (d_q != DW'(i));
      end
      for (int k = 0; k < 7; k++) begin
        leds_d[k] = glyph_bits[k];
      end
      dp_d = ~cur_dp;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q    <= '0;
      d_q    <= '0;
      pend_q <= '0;
      act_q  <= '0;
      leds_q <= '1;
      dp_q   <= 1'b1;
      an_q   <= '1;
    end else begin
      s_q    <= s_d;
      d_q    <= d_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      leds_q <= leds_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
    end
  end

  assign leds_o = leds_q;
  assign dp_o   = dp_q;
  assign an_o   = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int DC = 2;
  localparam int FRAME = ND * RD;

  logic          clk;
  logic          rst_n;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic          mode;
  logic          blank_lz;
  logic          load;
  logic [6:0]    leds;
  logic          dp;
  logic [3:0]    an;

  int checks;
  int failures;
  int cyc;

  seg7_scan_driver #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .DEAD_CYCLES(DC)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .value_i   (value),
    .dp_in_i   (dp_in),
    .mode_i    (mode),
    .blank_lz_i(blank_lz),
    .load_i    (load),
    .leds_o    (leds),
    .dp_o      (dp),
    .an_o      (an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges since reset release; output seen at a negedge reflects scan position cyc-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dpin;
    logic            mode;
    logic            blz;
    logic [3:0]      lit;
    logic [3:0][0:6] g;
    logic [3:0]      dp_low;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [15:0] val, input logic [3:0] dpin, input logic md,
                              input logic blz, input logic [3:0] lit,
                              input logic [0:6] g3, input logic [0:6] g2,
                              input logic [0:6] g1, input logic [0:6] g0,
                              input logic [3:0] dpl);
    vec_t v;
    v.value  = val;
    v.dpin   = dpin;
    v.mode   = md;
    v.blz    = blz;
    v.lit    = lit;
    v.g      = {g3, g2, g1, g0};
    v.dp_low = dpl;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [3:0] ean, input logic [0:6] eg, input logic edp);
    logic [6:0] el;
    for (int k = 0; k < 7; k++) el[k] = eg[k];
    checks++;
    if (an !== ean || leds !== el || dp !== edp) begin
      failures++;
      $display("FAIL %s: got an=%b leds=%b dp=%b, want an=%b leds=%b dp=%b",
               tag, an, leds, dp, ean, el, edp);
    end
  endtask

  task automatic chk_blank(input string tag);
    chk(tag, 4'b1111, 7'b111_1111, 1'b1);
  endtask

  function automatic logic [3:0] an_for(input int d);
    return ~(4'b0001 << d);
  endfunction

  task automatic load_vec(input vec_t v);
    @(negedge clk);
    value    = v.value;
    dp_in    = v.dpin;
    mode     = v.mode;
    blank_lz = v.blz;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic wait_state(input int m, input string tag);
    int k;
    k = 0;
    while ((cyc % FRAME) != m && k < 2 * FRAME) begin
      @(negedge clk);
      k++;
    end
    if ((cyc % FRAME) != m) begin
      checks++;
      failures++;
      $display("FAIL %s: scan position %0d never reached", tag, m);
    end
  endtask

  task automatic check_frame(input int idx);
    int lp, k, p, s, d;
    lp = cyc;
    k  = 0;
    while (!(((cyc - 1) % FRAME) == 0 && cyc >= lp + 16) && k < 4 * FRAME) begin
      @(negedge clk);
      k++;
    end
    for (int t = 0; t < FRAME; t++) begin
      p = cyc - 1;
      s = p % RD;
      d = (p / RD) % ND;
      if (s < DC || !vecs[idx].lit[d])
        chk($sformatf("vec%0d d%0d s%0d", idx, d, s), 4'b1111, 7'b111_1111, 1'b1);
      else
        chk($sformatf("vec%0d d%0d s%0d", idx, d, s), an_for(d), vecs[idx].g[d], ~vecs[idx].dp_low[d]);
      @(negedge clk);
    end
  endtask

  // Release reset at a negedge and expect DC+1 blank cycles, then zeroes (active cleared).
  task automatic release_and_check(input string tag);
    int p, s, d;
    rst_n = 1'b1;
    #1;
    chk_blank({tag, " release"});
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      p = cyc - 1;
      s = p % RD;
      d = (p / RD) % ND;
      if (s < DC)
        chk_blank($sformatf("%s t%0d", tag, t));
      else
        chk($sformatf("%s t%0d", tag, t), an_for(d), 7'b000_0001, 1'b1);
    end
  endtask

  initial begin
    int base, p, s, d;
    logic [0:6] eg;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    value    = '0;
    dp_in    = '0;
    mode     = 1'b0;
    blank_lz = 1'b0;
    load     = 1'b0;

    vecs[0]  = mk(16'h12AF, 4'b0000, 0, 0, 4'b1111, 7'b100_1111, 7'b001_0010, 7'b000_1000, 7'b011_1000, 4'b0000);
    vecs[1]  = mk(16'hABEF, 4'b0000, 1, 0, 4'b1111, 7'b111_0001, 7'b000_0001, 7'b111_1111, 7'b111_1111, 4'b0000);
    vecs[2]  = mk(16'h0070, 4'b0000, 0, 1, 4'b0011, 7'b111_1111, 7'b111_1111, 7'b000_1111, 7'b000_0001, 4'b0000);
    vecs[3]  = mk(16'h0000, 4'b0000, 0, 1, 4'b0001, 7'b111_1111, 7'b111_1111, 7'b111_1111, 7'b000_0001, 4'b0000);
    vecs[4]  = mk(16'h1234, 4'b0100, 0, 0, 4'b1111, 7'b100_1111, 7'b001_0010, 7'b000_0110, 7'b100_1100, 4'b0100);
    vecs[5]  = mk(16'h0034, 4'b1000, 0, 1, 4'b0011, 7'b111_1111, 7'b111_1111, 7'b000_0110, 7'b100_1100, 4'b0000);
    vecs[6]  = mk(16'hCD98, 4'b0000, 1, 0, 4'b1111, 7'b010_0100, 7'b011_0000, 7'b000_0100, 7'b000_0000, 4'b0000);
    vecs[7]  = mk(16'h5BCD, 4'b0000, 0, 0, 4'b1111, 7'b010_0100, 7'b110_0000, 7'b011_0001, 7'b100_0010, 4'b0000);
    vecs[8]  = mk(16'h60E0, 4'b0000, 0, 1, 4'b1111, 7'b010_0000, 7'b000_0001, 7'b011_0000, 7'b000_0001, 4'b0000);
    vecs[9]  = mk(16'h00A0, 4'b0000, 1, 1, 4'b0011, 7'b111_1111, 7'b111_1111, 7'b111_0001, 7'b000_0001, 4'b0000);
    vecs[10] = mk(16'h4567, 4'b0000, 1, 0, 4'b1111, 7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111, 4'b0000);
    vecs[11] = mk(16'h0123, 4'b0000, 1, 0, 4'b1111, 7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110, 4'b0000);

    #3 rst_n = 1'b0;
    #1;
    chk_blank("reset async");
    @(negedge clk);
    @(negedge clk);
    chk_blank("reset held");
    release_and_check("first release");

    for (int i = 0; i < 12; i++) begin
      load_vec(vecs[i]);
      check_frame(i);
    end

    // Multiple loads in slot 0, then a load exactly on the slot1->slot2 wrap edge.
    wait_state(3, "load seq");
    base = cyc - 3;
    for (int t = 3; t <= FRAME; t++) begin
      p = cyc - 1;
      s = p % RD;
      d = (p / RD) % ND;
      if (d == 0 || d == 3) eg = 7'b000_0110;
      else                  eg = 7'b001_0010;
      if (cyc != base + t) begin
        checks++;
        failures++;
        $display("FAIL load seq align: cyc=%0d want %0d", cyc, base + t);
      end
      if (s < DC) chk_blank($sformatf("load seq t%0d", t));
      else        chk($sformatf("load seq t%0d", t), an_for(d), eg, 1'b1);
      mode     = 1'b0;
      blank_lz = 1'b0;
      dp_in    = 4'b0000;
      load     = (t == 3 || t == 5 || t == 15);
      value    = (t == 3) ? 16'h1111 : (t == 5) ? 16'h2222 : 16'h3333;
      @(negedge clk);
    end
    load = 1'b0;

    // Reset in the middle of digit 2's lit phase.
    wait_state(20, "mid reset");
    chk("pre-reset slot2", 4'b1011, 7'b000_0110, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_blank("mid reset immediate");
    @(negedge clk);
    @(negedge clk);
    chk_blank("mid reset held");
    release_and_check("mid release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
